// File: rtl/multicycle_control.sv
// Multicycle main control FSM: fetches, decodes and sequences ld/sd/R-type/beq
// through FETCH/DECODE/EXEC/MEM/WB, owning the PC and instruction register.
//
// Ports:
//   clk, rst                  clock, async active-high reset
//   imem_req/addr/ack/rdata   instruction fetch handshake (addr = pc)
//   dmem_req/we/ack           data access handshake (we = store)
//   alu_zero                  ALU result == 0, sampled in EXEC for beq
//   ctrl_ALU_op               00 add, 01 sub, 10 R-type (funct fields)
//   funct3/funct7/rs1/rs2/rd  instruction fields decoded from IR
//   imm                       sign-extended I/S/B immediate, else 0
//   alu_src                   ALU operand B = imm (ld/sd in EXEC)
//   reg_write, mem_to_reg     writeback strobe and source select
//   pc, retire                program counter, advance pulse
//   illegal_instr             trap flag (optional feature)
//
// Optional feature: define MULTICYCLE_CTRL_TRAP_EN to make an illegal
// opcode stop the machine in TRAP with illegal_instr held high until reset.
// Without it an illegal opcode retires as a NOP from DECODE.

module multicycle_control #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ack,
    input  logic            alu_zero,
    output logic [1:0]      ctrl_ALU_op,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] imm,
    output logic            alu_src,
    output logic            reg_write,
    output logic            mem_to_reg,
    output logic [XLEN-1:0] pc,
    output logic            retire,
    output logic            illegal_instr
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_R   = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
`ifdef MULTICYCLE_CTRL_TRAP_EN
        ,
        S_TRAP
`endif
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [31:0]     ir;
    logic [31:0]     ir_n;
    logic [XLEN-1:0] pc_n;
    logic [XLEN-1:0] pc_seq;
    logic [XLEN-1:0] pc_br;
    logic            fetch_req;

    logic [6:0] opcode;
    logic       is_ld;
    logic       is_sd;
    logic       is_r;
    logic       is_beq;
    logic       is_legal;

    // ------------------------------------------------------------------
    // Instruction field decode (combinational from IR)
    // ------------------------------------------------------------------
    assign opcode = ir[6:0];
    assign funct3 = ir[14:12];
    assign funct7 = ir[31:25];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign rd     = ir[11:7];

    assign is_ld    = (opcode == OP_LOAD)   && (funct3 == 3'b011);
    assign is_sd    = (opcode == OP_STORE)  && (funct3 == 3'b011);
    assign is_r     = (opcode == OP_REG);
    assign is_beq   = (opcode == OP_BRANCH) && (funct3 == 3'b000);
    assign is_legal = is_ld | is_sd | is_r | is_beq;

    always_comb begin
        imm = '0;
        if (is_ld) begin
            imm = {{(XLEN-12){ir[31]}}, ir[31:20]};
        end else if (is_sd) begin
            imm = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
        end else if (is_beq) begin
            // B-type: 13-bit signed offset, bit 0 implicitly zero
            imm = {{(XLEN-13){ir[31]}}, ir[31], ir[7],
                   ir[30:25], ir[11:8], 1'b0};
        end
    end

    // Both PC successors wrap modulo 2^XLEN
    assign pc_seq = pc + XLEN'(4);
    assign pc_br  = pc + imm;

    // ------------------------------------------------------------------
    // State, PC and IR registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
            pc    <= RESET_PC;
            ir    <= '0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            ir    <= ir_n;
        end
    end

    // ------------------------------------------------------------------
    // Next state and datapath control
    // ------------------------------------------------------------------
    always_comb begin
        state_n     = state;
        pc_n        = pc;
        ir_n        = ir;
        fetch_req   = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        ctrl_ALU_op = ALU_ADD;
        alu_src     = 1'b0;
        reg_write   = 1'b0;
        mem_to_reg  = 1'b0;
        retire      = 1'b0;

        case (state)
            S_FETCH: begin
                fetch_req = 1'b1;
                if (imem_ack) begin
                    ir_n    = imem_rdata;
                    state_n = S_DECODE;
                end
            end

            S_DECODE: begin
                if (is_legal) begin
                    state_n = S_EXEC;
                end else begin
`ifdef MULTICYCLE_CTRL_TRAP_EN
                    state_n = S_TRAP;
`else
                    pc_n    = pc_seq;
                    retire  = 1'b1;
                    state_n = S_FETCH;
`endif
                end
            end

            S_EXEC: begin
                if (is_r) begin
                    ctrl_ALU_op = ALU_R;
                    state_n     = S_WB;
                end else if (is_beq) begin
                    ctrl_ALU_op = ALU_SUB;
                    pc_n        = alu_zero ? pc_br : pc_seq;
                    retire      = 1'b1;
                    state_n     = S_FETCH;
                end else begin
                    // ld / sd: address = rs1 + imm
                    ctrl_ALU_op = ALU_ADD;
                    alu_src     = 1'b1;
                    state_n     = S_MEM;
                end
            end

            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_sd;
                if (dmem_ack) begin
                    if (is_sd) begin
                        pc_n    = pc_seq;
                        retire  = 1'b1;
                        state_n = S_FETCH;
                    end else begin
                        state_n = S_WB;
                    end
                end
            end

            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = is_ld;
                pc_n       = pc_seq;
                retire     = 1'b1;
                state_n    = S_FETCH;
            end

`ifdef MULTICYCLE_CTRL_TRAP_EN
            S_TRAP: begin
                state_n = S_TRAP;
            end
`endif

            default: begin
                state_n = S_FETCH;
            end
        endcase
    end

    // Reset forces FETCH, so only the fetch request needs explicit gating
    // to drop during the reset pulse itself.
    assign imem_req  = fetch_req & ~rst;
    assign imem_addr = pc;

`ifdef MULTICYCLE_CTRL_TRAP_EN
    assign illegal_instr = (state == S_TRAP);
`else
    assign illegal_instr = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control: random and directed instruction stream
// with random memory wait states, scoreboard of reference-model results.

module tb_multicycle_control;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;
    logic        alu_zero;
    logic [1:0]  ctrl_ALU_op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [63:0] imm;
    logic        alu_src;
    logic        reg_write;
    logic        mem_to_reg;
    logic [63:0] pc;
    logic        retire;
    logic        illegal_instr;

    multicycle_control #(.XLEN(64), .RESET_PC(64'h0)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .alu_zero(alu_zero), .ctrl_ALU_op(ctrl_ALU_op),
        .funct3(funct3), .funct7(funct7),
        .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
        .alu_src(alu_src), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .pc(pc), .retire(retire),
        .illegal_instr(illegal_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc_new;
        logic [63:0] imm;
        bit          rw;
        bit          m2r;
        bit          is_sd;
        bit          is_mem;
        bit          ill;
        logic [1:0]  op;
        bit          asrc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        int          lat;
    } exp_t;

    exp_t q[$];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, expv, $time);
        end
    endtask

    task automatic flag(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Reference model: architectural effect of one instruction word
    function automatic exp_t model(input logic [31:0] w,
                                   input logic [63:0] p, input bit az,
                                   input int iw, input int dw);
        exp_t   e;
        longint v;
        e = '{default: '0};
        e.rd  = w[11:7];
        e.rs1 = w[19:15];
        e.rs2 = w[24:20];
        e.f3  = w[14:12];
        e.f7  = w[31:25];
        e.pc_new = p + 64'd4;
        if (w[6:0] == 7'h03 && w[14:12] == 3'd3) begin
            v = longint'(w[31:20]);
            if (v >= 2048) v -= 4096;
            e.imm = v; e.asrc = 1; e.is_mem = 1;
            e.rw = 1; e.m2r = 1; e.lat = 5 + iw + dw;
        end else if (w[6:0] == 7'h23 && w[14:12] == 3'd3) begin
            v = longint'(w[31:25]) * 32 + longint'(w[11:7]);
            if (v >= 2048) v -= 4096;
            e.imm = v; e.asrc = 1; e.is_mem = 1;
            e.is_sd = 1; e.lat = 4 + iw + dw;
        end else if (w[6:0] == 7'h33) begin
            e.op = 2'b10; e.rw = 1; e.lat = 4 + iw;
        end else if (w[6:0] == 7'h63 && w[14:12] == 3'd0) begin
            v = longint'(w[31]) * 4096 + longint'(w[7]) * 2048
              + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2;
            if (v >= 4096) v -= 8192;
            e.imm = v; e.op = 2'b01; e.lat = 3 + iw;
            if (az) e.pc_new = p + v;
        end else begin
            e.ill = 1; e.lat = 2 + iw;
        end
        return e;
    endfunction

    // Directed words first, then random ones
    logic [31:0] dir_w [7] = '{32'h002081B3, 32'h402081B3,
                               32'h0080B283, 32'h0050B823,
                               32'h00208863, 32'h00208863,
                               32'hFFFFFFFF};
    int dir_dw [7] = '{0, 0, 3, 1, 0, 0, 0};
    bit dir_az [7] = '{0, 0, 0, 0, 1, 0, 0};
`ifdef MULTICYCLE_CTRL_TRAP_EN
    int ndir = 6;
`else
    int ndir = 7;
`endif

    logic [63:0] mpc = 64'h0;
    int issued   = 0;
    int n_target = 0;
    bit drv_en   = 0;
    bit use_dir  = 1;

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        int k;
        w = $urandom;
`ifdef MULTICYCLE_CTRL_TRAP_EN
        k = $urandom_range(0, 3);
`else
        k = $urandom_range(0, 4);
`endif
        case (k)
            0: begin
                w[6:0] = 7'h33;
                w[31:25] = ($urandom % 2) ? 7'h20 : 7'h00;
            end
            1: begin w[6:0] = 7'h03; w[14:12] = 3'd3; end
            2: begin w[6:0] = 7'h23; w[14:12] = 3'd3; end
            3: begin w[6:0] = 7'h63; w[14:12] = 3'd0; end
            default: if ($urandom % 2) w[6:0] = 7'h03;
        endcase
        return w;
    endfunction

    // Driver: instruction/data memory with random waits, junk acks
    // outside the matching access
    initial begin
        logic [31:0] cur_w;
        bit          cur_az;
        int          cur_iw, cur_dw, iw_left, dw_left;
        bit          fetching;
        exp_t        e;
        imem_ack = 0; imem_rdata = 0; dmem_ack = 0; alu_zero = 0;
        fetching = 0; iw_left = 0; dw_left = 0;
        cur_w = 0; cur_az = 0; cur_iw = 0; cur_dw = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                imem_ack = 0; dmem_ack = 0; fetching = 0;
                continue;
            end
            if (imem_req && drv_en && issued < n_target) begin
                if (!fetching) begin
                    fetching = 1;
                    if (use_dir && issued < ndir) begin
                        cur_w  = dir_w[issued];
                        cur_az = dir_az[issued];
                        cur_iw = 0;
                        cur_dw = dir_dw[issued];
                    end else begin
                        cur_w  = rand_word();
                        cur_az = bit'($urandom % 2);
                        cur_iw = $urandom_range(0, 2);
                        cur_dw = $urandom_range(0, 3);
                    end
                    iw_left = cur_iw;
                end
                if (iw_left == 0) begin
                    imem_ack   = 1;
                    imem_rdata = cur_w;
                    alu_zero   = cur_az;
                    e = model(cur_w, mpc, cur_az, cur_iw, cur_dw);
                    q.push_back(e);
                    mpc      = e.pc_new;
                    dw_left  = cur_dw;
                    fetching = 0;
                    issued++;
                end else begin
                    imem_ack = 0;
                    iw_left--;
                end
            end else if (imem_req) begin
                imem_ack = 0;
            end else begin
                imem_ack   = ($urandom % 4) == 0;
                imem_rdata = $urandom;
            end
            if (dmem_req) begin
                if (dw_left == 0) dmem_ack = 1;
                else begin dmem_ack = 0; dw_left--; end
            end else begin
                dmem_ack = ($urandom % 4) == 0;
            end
        end
    end

    // Monitor: checks against the scoreboard head
    bit          mon_en    = 0;
    logic [63:0] exp_pc    = 64'h0;
    int          exec_cd   = 0;
    bit          mem_seen  = 0;
    bit          have_prev = 0;
    int          cyc       = 0;
    int          last_ret  = 0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!mon_en) continue;
            cyc++;
            chk("pc", pc, exp_pc);
            if (imem_req) chk("imem_addr", imem_addr, exp_pc);
            if (exec_cd > 0) begin
                exec_cd--;
                if (exec_cd == 0) begin
                    if (q.size() == 0) flag("exec_no_entry");
                    else begin
                        e = q[0];
                        chk("alu_op", 64'(ctrl_ALU_op), 64'(e.op));
                        chk("alu_src", 64'(alu_src), 64'(e.asrc));
                        chk("funct3", 64'(funct3), 64'(e.f3));
                        chk("funct7", 64'(funct7), 64'(e.f7));
                        chk("rs1", 64'(rs1), 64'(e.rs1));
                        chk("rs2", 64'(rs2), 64'(e.rs2));
                        chk("imm", imm, e.imm);
                    end
                end
            end
            if (dmem_req && !mem_seen) begin
                mem_seen = 1;
                if (q.size() == 0 || !q[0].is_mem) flag("dmem_req_stray");
                else chk("dmem_we", 64'(dmem_we), 64'(q[0].is_sd));
            end
            if (reg_write && !retire) flag("reg_write_stray");
            if (retire) begin
                if (q.size() == 0) flag("retire_no_entry");
                else begin
                    e = q.pop_front();
                    chk("reg_write", 64'(reg_write), 64'(e.rw));
                    chk("illegal", 64'(illegal_instr), 64'h0);
                    if (e.rw) begin
                        chk("mem_to_reg", 64'(mem_to_reg), 64'(e.m2r));
                        chk("rd", 64'(rd), 64'(e.rd));
                    end
                    if (have_prev)
                        chk("latency", 64'(cyc - last_ret), 64'(e.lat));
                    exp_pc = e.pc_new;
                    if (e.ill) exec_cd = 0;
                end
                last_ret  = cyc;
                have_prev = 1;
                mem_seen  = 0;
            end
            if (imem_req && imem_ack) exec_cd = 2;
        end
    end

    task automatic drain();
        int i;
        i = 0;
        while (i < 5000 && !(issued == n_target && q.size() == 0)) begin
            @(posedge clk);
            i++;
        end
        if (!(issued == n_target && q.size() == 0)) flag("drain_timeout");
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pc", pc, 64'h0);
        chk("rst_imem_req", 64'(imem_req), 64'h0);
        chk("rst_dmem_req", 64'(dmem_req), 64'h0);
        chk("rst_retire", 64'(retire), 64'h0);
        chk("rst_reg_write", 64'(reg_write), 64'h0);
        chk("rst_alu_op", 64'(ctrl_ALU_op), 64'h0);
        chk("rst_illegal", 64'(illegal_instr), 64'h0);

        @(negedge clk);
        rst      = 0;
        exp_pc   = 64'h0;
        n_target = ndir + 150;
        drv_en   = 1;
        mon_en   = 1;
        drain();

        // Reset in the middle of a stalled fetch
        drv_en = 0;
        @(posedge clk);
        #1;
        if (!imem_req) flag("pre_rst_not_fetching");
        mon_en = 0;
        #2;
        rst = 1;
        #1;
        chk("mid_rst_imem_req", 64'(imem_req), 64'h0);
        chk("mid_rst_pc", pc, 64'h0);
        chk("mid_rst_reg_write", 64'(reg_write), 64'h0);
        chk("mid_rst_dmem_req", 64'(dmem_req), 64'h0);
        chk("mid_rst_retire", 64'(retire), 64'h0);
        @(negedge clk);
        rst = 0;
        q.delete();
        mpc       = 64'h0;
        exp_pc    = 64'h0;
        issued    = 0;
        use_dir   = 0;
        exec_cd   = 0;
        mem_seen  = 0;
        have_prev = 0;
        n_target  = 30;
        #1;
        chk("post_rst_imem_req", 64'(imem_req), 64'h1);
        chk("post_rst_imem_addr", imem_addr, 64'h0);
        drv_en = 1;
        mon_en = 1;
        drain();

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
